// File: rtl/pll_dri_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_dri_pkg : shared encodings for the PLL DRI initiator             |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package pll_dri_pkg;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;

  localparam logic [1:0] OP_READ    = 2'b00;
  localparam logic [1:0] OP_WRITE   = 2'b01;
  localparam logic [1:0] OP_RMW     = 2'b10;
  localparam logic [1:0] OP_ILLEGAL = 2'b11;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_ILLEGAL = 2'b10;

  localparam int CTRL_RD_BIT   = 0;
  localparam int CTRL_WR_BIT   = 1;
  localparam int CTRL_ADDR_LSB = 2;
  localparam int CTRL_ADDR_MSB = 10;
  localparam int ACK_BIT       = 32;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    MERGE   = 3'd3,
    WR_REQ  = 3'd4,
    WR_WAIT = 3'd5,
    RESP    = 3'd6
  } dri_state_t;

  // Mask bit set selects the new write bit, clear keeps the bit just read.
  function automatic logic [DATA_W-1:0] rmw_merge(input logic [DATA_W-1:0] rdata,
                                                  input logic [DATA_W-1:0] wdata,
                                                  input logic [DATA_W-1:0] mask);
    return (rdata & ~mask) | (wdata & mask);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pll_dri_master_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_dri_master_if : command/response port plus PLL DRI pins          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface pll_dri_master_if;
  import pll_dri_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;
  logic [DATA_W-1:0] cmd_mask;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_rdata;
  logic [1:0]        rsp_err;
  logic [10:0]       dri_ctrl;
  logic [32:0]       dri_wdata;
  logic [32:0]       dri_rdata;
  logic              dri_interrupt;
  logic              irq_sticky;
  logic              irq_clr;

  modport master (
    input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
           dri_rdata, dri_interrupt, irq_clr,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err, dri_ctrl, dri_wdata, irq_sticky
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_mask, rsp_ready,
           dri_rdata, dri_interrupt, irq_clr,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err, dri_ctrl, dri_wdata, irq_sticky
  );

endinterface
`default_nettype wire

// File: rtl/pll_dri_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_dri_timeout : acknowledge wait counter with terminal-count flag  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pll_dri_timeout #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tc
);

  localparam logic [15:0] c_TERMINAL = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_count;

  // Holds at terminal count so the flag stays asserted until cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_tc) begin
      r_count <= r_count + 16'd1;
    end
  end

  assign o_tc = (r_count == c_TERMINAL);

endmodule
`default_nettype wire

// File: rtl/pll_dri_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | pll_dri_master : sequences read/write/RMW commands onto the PLL DRI  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module pll_dri_master
  import pll_dri_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  pll_dri_master_if.master bus
);

  dri_state_t        r_state;
  dri_state_t        w_next_state;
  logic [1:0]        r_op;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_mask;
  logic [DATA_W-1:0] r_wword;
  logic              r_rd_stb;
  logic              r_wr_stb;
  logic              r_cmd_ready;
  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  logic [1:0]        r_rsp_err;
  logic              r_irq;

  logic              w_accept;
  logic              w_ack;
  logic              w_in_wait;
  logic              w_tc;
  logic [DATA_W-1:0] w_rsp_rdata_nxt;
  logic [1:0]        w_rsp_err_nxt;
  logic [DATA_W-1:0] w_wword_nxt;

  assign w_ack     = bus.dri_rdata[ACK_BIT];
  assign w_in_wait = (r_state == RD_WAIT) || (r_state == WR_WAIT);

  pll_dri_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (!w_in_wait),
    .i_en  (w_in_wait && !w_ack),
    .o_tc  (w_tc)
  );

  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    w_wword_nxt     = r_wword;
    case (r_state)
      IDLE: begin
        if (bus.cmd_valid && r_cmd_ready) begin
          w_accept        = 1'b1;
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = ERR_OK;
          case (bus.cmd_op)
            OP_READ, OP_RMW: w_next_state = RD_REQ;
            OP_WRITE: begin
              w_next_state = WR_REQ;
              w_wword_nxt  = bus.cmd_wdata;
            end
            default: begin
              w_next_state  = RESP;
              w_rsp_err_nxt = ERR_ILLEGAL;
            end
          endcase
        end
      end
      RD_REQ: w_next_state = RD_WAIT;
      RD_WAIT: begin
        // The read value is parked in the response register; RMW merges from it.
        if (w_ack) begin
          w_rsp_rdata_nxt = bus.dri_rdata[DATA_W-1:0];
          w_next_state    = (r_op == OP_RMW) ? MERGE : RESP;
        end else if (w_tc) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = ERR_TIMEOUT;
          w_next_state    = RESP;
        end
      end
      MERGE: begin
        w_wword_nxt  = rmw_merge(r_rsp_rdata, r_wdata, r_mask);
        w_next_state = WR_REQ;
      end
      WR_REQ: w_next_state = WR_WAIT;
      WR_WAIT: begin
        if (w_ack) begin
          w_next_state = RESP;
        end else if (w_tc) begin
          w_rsp_rdata_nxt = '0;
          w_rsp_err_nxt   = ERR_TIMEOUT;
          w_next_state    = RESP;
        end
      end
      RESP: begin
        if (bus.rsp_ready) w_next_state = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Every pin is a flop decoded from the next state, so strobes land in the REQ cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_op        <= OP_READ;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_mask      <= '0;
      r_wword     <= '0;
      r_rd_stb    <= 1'b0;
      r_wr_stb    <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= ERR_OK;
    end else begin
      r_state     <= w_next_state;
      r_rd_stb    <= (w_next_state == RD_REQ);
      r_wr_stb    <= (w_next_state == WR_REQ);
      r_cmd_ready <= (w_next_state == IDLE);
      r_rsp_valid <= (w_next_state == RESP);
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
      r_wword     <= w_wword_nxt;
      if (w_accept) begin
        r_op    <= bus.cmd_op;
        r_addr  <= bus.cmd_addr;
        r_wdata <= bus.cmd_wdata;
        r_mask  <= bus.cmd_mask;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_irq <= 1'b0;
    end else if (bus.dri_interrupt) begin
      r_irq <= 1'b1;
    end else if (bus.irq_clr) begin
      r_irq <= 1'b0;
    end
  end

  assign bus.cmd_ready                            = r_cmd_ready;
  assign bus.rsp_valid                            = r_rsp_valid;
  assign bus.rsp_rdata                            = r_rsp_rdata;
  assign bus.rsp_err                              = r_rsp_err;
  assign bus.dri_ctrl[CTRL_ADDR_MSB:CTRL_ADDR_LSB] = r_addr;
  assign bus.dri_ctrl[CTRL_WR_BIT]                = r_wr_stb;
  assign bus.dri_ctrl[CTRL_RD_BIT]                = r_rd_stb;
  assign bus.dri_wdata                            = {1'b0, r_wword};
  assign bus.irq_sticky                           = r_irq;

endmodule
`default_nettype wire

// File: tb/tb_pll_dri_master.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_pll_dri_master : randomized scoreboard bench for pll_dri_master   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_pll_dri_master;
  import pll_dri_pkg::*;

  localparam int T = 4;

  typedef struct {
    logic [31:0] rdata;
    logic [1:0]  err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    bit          wr;
    logic [8:0]  addr;
    logic [31:0] wd;
  } stb_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;

  exp_t rsp_q[$];
  stb_t stb_q[$];
  logic [31:0] ref_mem [512];
  logic [31:0] resp_mem[512];

  int cfg_k = 0;
  bit cfg_noack = 1'b0;
  int hold_low = 0;

  pll_dri_master_if bus();

  pll_dri_master #(.TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
  endtask

  function automatic stb_t mk_stb(input bit wr, input logic [8:0] a, input logic [31:0] d);
    stb_t s;
    s.wr = wr; s.addr = a; s.wd = d;
    return s;
  endfunction

  // Reference: bitwise choose between old register contents and new data.
  function automatic logic [31:0] ref_merge(input logic [31:0] old, input logic [31:0] nw,
                                            input logic [31:0] sel);
    logic [31:0] r;
    for (int b = 0; b < 32; b++) r[b] = sel[b] ? nw[b] : old[b];
    return r;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [8:0] addr, input logic [31:0] wd,
                       input logic [31:0] mk, input int k, input bit noack, input bit expect_rsp);
    exp_t e;
    logic [31:0] old;
    logic [31:0] nw;
    int guard;
    guard = 0;
    @(negedge clk);
    bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_addr = addr;
    bus.cmd_wdata = wd; bus.cmd_mask = mk;
    #2;
    while (!bus.cmd_ready) begin
      guard++;
      if (guard > 300) begin
        chk("cmd_accept_timeout", 64'(guard), 64'd0);
        bus.cmd_valid = 1'b0;
        return;
      end
      @(negedge clk); #2;
    end
    cfg_k = k; cfg_noack = noack;
    e.acc = cyc; e.rdata = '0; e.err = ERR_OK; e.lat = 0;
    case (op)
      OP_READ: begin
        stb_q.push_back(mk_stb(1'b0, addr, 32'h0));
        if (noack) begin e.err = ERR_TIMEOUT; e.lat = T + 3; end
        else begin e.rdata = ref_mem[addr]; e.lat = 3 + k; end
      end
      OP_WRITE: begin
        stb_q.push_back(mk_stb(1'b1, addr, wd));
        if (noack) begin e.err = ERR_TIMEOUT; e.lat = T + 3; end
        else begin ref_mem[addr] = wd; e.lat = 3 + k; end
      end
      OP_RMW: begin
        stb_q.push_back(mk_stb(1'b0, addr, 32'h0));
        if (noack) begin e.err = ERR_TIMEOUT; e.lat = T + 3; end
        else begin
          old = ref_mem[addr];
          nw = ref_merge(old, wd, mk);
          stb_q.push_back(mk_stb(1'b1, addr, nw));
          ref_mem[addr] = nw;
          e.rdata = old;
          e.lat = 6 + 2 * k;
        end
      end
      default: begin e.err = ERR_ILLEGAL; e.lat = 1; end
    endcase
    if (expect_rsp) rsp_q.push_back(e);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    bus.cmd_op = 2'($urandom_range(0, 3)); bus.cmd_wdata = $urandom;
  endtask

  // PLL-side responder: acks k wait cycles after a strobe, plus harmless spurious acks.
  initial begin
    bit pend = 1'b0;
    bit pwr = 1'b0;
    int cnt = 0;
    logic [8:0] paddr = '0;
    logic [31:0] pwd = '0;
    bus.dri_rdata = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        pend = 1'b0;
        bus.dri_rdata = '0;
        continue;
      end
      if (pend && cnt == 0) begin
        if (pwr) begin resp_mem[paddr] = pwd; bus.dri_rdata = {1'b1, 32'($urandom)}; end
        else bus.dri_rdata = {1'b1, resp_mem[paddr]};
        pend = 1'b0;
      end else begin
        if (pend) cnt--;
        if ((bus.cmd_ready || bus.dri_ctrl[1:0] != 2'b00) && $urandom_range(0, 3) == 0)
          bus.dri_rdata = {1'b1, 32'($urandom)};
        else
          bus.dri_rdata = {1'b0, 32'($urandom)};
      end
      #2;
      if (rst_n && bus.dri_ctrl[1:0] != 2'b00 && !cfg_noack) begin
        pend = 1'b1; cnt = cfg_k; pwr = bus.dri_ctrl[1];
        paddr = bus.dri_ctrl[10:2]; pwd = bus.dri_wdata[31:0];
      end
    end
  end

  // Strobe monitor: shape of every strobe and its address/data against the expectation queue.
  initial begin
    bit prev = 1'b0;
    stb_t s;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin prev = 1'b0; continue; end
      if (bus.dri_ctrl[1:0] != 2'b00) begin
        chk("strobe_exclusive", 64'(bus.dri_ctrl[1:0] == 2'b11), 64'd0);
        chk("strobe_single_cycle", 64'(prev), 64'd0);
        chk("wdata_bit32", 64'(bus.dri_wdata[32]), 64'd0);
        if (stb_q.size() == 0) chk("unexpected_strobe", 64'(bus.dri_ctrl), 64'd0);
        else begin
          s = stb_q.pop_front();
          chk("strobe_kind", 64'(bus.dri_ctrl[1:0]), s.wr ? 64'd2 : 64'd1);
          chk("strobe_addr", 64'(bus.dri_ctrl[10:2]), 64'(s.addr));
          if (s.wr) chk("strobe_wdata", 64'(bus.dri_wdata[31:0]), 64'(s.wd));
        end
      end
      prev = (bus.dri_ctrl[1:0] != 2'b00);
    end
  end

  always @(negedge clk) begin
    if (hold_low > 0) begin bus.rsp_ready = 1'b0; hold_low = hold_low - 1; end
    else bus.rsp_ready = ($urandom_range(0, 2) != 0);
  end

  // Response monitor: pops the scoreboard on each new response, checks stability while stalled.
  initial begin
    bit prev = 1'b0;
    exp_t e;
    logic [31:0] hold_d = '0;
    logic [1:0]  hold_e = '0;
    forever begin
      @(negedge clk); #2;
      if (!rst_n) begin prev = 1'b0; continue; end
      if (bus.rsp_valid) begin
        chk("cmd_ready_in_resp", 64'(bus.cmd_ready), 64'd0);
        if (!prev) begin
          if (rsp_q.size() == 0) chk("unexpected_response", 64'(bus.rsp_err), 64'hFF);
          else begin
            e = rsp_q.pop_front();
            chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
            chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
            chk("rsp_latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          hold_d = bus.rsp_rdata; hold_e = bus.rsp_err;
        end else begin
          chk("rsp_rdata_stable", 64'(bus.rsp_rdata), 64'(hold_d));
          chk("rsp_err_stable", 64'(bus.rsp_err), 64'(hold_e));
        end
        prev = !bus.rsp_ready;
      end else begin
        if (prev) chk("rsp_dropped_early", 64'd0, 64'd1);
        prev = 1'b0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    logic [31:0] v;
    int guard;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_addr = '0; bus.cmd_wdata = '0;
    bus.cmd_mask = '0; bus.dri_interrupt = 1'b0; bus.irq_clr = 1'b0;
    for (int i = 0; i < 512; i++) begin v = $urandom; ref_mem[i] = v; resp_mem[i] = v; end
    ref_mem[9'h012] = 32'hDEADBEEF; resp_mem[9'h012] = 32'hDEADBEEF;
    ref_mem[9'h055] = 32'hFFFF0000; resp_mem[9'h055] = 32'hFFFF0000;

    repeat (3) @(negedge clk);
    #2;
    chk("rst_ctrl", 64'(bus.dri_ctrl), 64'd0);
    chk("rst_wdata", 64'(bus.dri_wdata), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("rst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("rst_irq", 64'(bus.irq_sticky), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    #2;
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    issue(OP_READ,  9'h012, 32'h0, 32'h0, 0, 1'b0, 1'b1);
    issue(OP_WRITE, 9'h1FF, 32'h00000014, 32'h0, 0, 1'b0, 1'b1);
    issue(OP_READ,  9'h1FF, 32'h0, 32'h0, 1, 1'b0, 1'b1);
    issue(OP_RMW,   9'h055, 32'h000000AA, 32'h000000FF, 0, 1'b0, 1'b1);
    issue(OP_READ,  9'h055, 32'h0, 32'h0, 2, 1'b0, 1'b1);
    issue(OP_READ,  9'h010, 32'h0, 32'h0, 0, 1'b1, 1'b1);
    issue(OP_RMW,   9'h011, 32'h12345678, 32'hFFFFFFFF, 0, 1'b1, 1'b1);
    issue(OP_WRITE, 9'h013, 32'hCAFEF00D, 32'h0, 0, 1'b1, 1'b1);
    hold_low = 13;
    issue(OP_ILLEGAL, 9'h0AA, 32'hFFFFFFFF, 32'hFFFFFFFF, 0, 1'b0, 1'b1);

    for (int n = 0; n < 150; n++) begin
      issue(2'($urandom_range(0, 3)), 9'($urandom_range(0, 511)), $urandom, $urandom,
            $urandom_range(0, T - 1), ($urandom_range(0, 7) == 0), 1'b1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    guard = 0;
    while (rsp_q.size() != 0 && guard < 300) begin @(negedge clk); guard++; end
    chk("drain_responses", 64'(rsp_q.size()), 64'd0);

    @(negedge clk); bus.dri_interrupt = 1'b1; bus.irq_clr = 1'b1;
    @(negedge clk); bus.dri_interrupt = 1'b0; bus.irq_clr = 1'b0;
    #2; chk("irq_set_wins", 64'(bus.irq_sticky), 64'd1);
    @(negedge clk); bus.irq_clr = 1'b1;
    @(negedge clk); bus.irq_clr = 1'b0;
    #2; chk("irq_clear", 64'(bus.irq_sticky), 64'd0);
    @(negedge clk); #2; chk("irq_stays_clear", 64'(bus.irq_sticky), 64'd0);
    @(negedge clk); bus.dri_interrupt = 1'b1;
    @(negedge clk); bus.dri_interrupt = 1'b0;
    #2; chk("irq_set", 64'(bus.irq_sticky), 64'd1);
    repeat (3) @(negedge clk);
    #2; chk("irq_sticky_hold", 64'(bus.irq_sticky), 64'd1);

    // Abort a read sitting in RD_WAIT; no response may follow.
    issue(OP_READ, 9'h077, 32'h0, 32'h0, 0, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("arst_ctrl", 64'(bus.dri_ctrl), 64'd0);
    chk("arst_wdata", 64'(bus.dri_wdata), 64'd0);
    chk("arst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("arst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
    chk("arst_rsp_err", 64'(bus.rsp_err), 64'd0);
    chk("arst_irq", 64'(bus.irq_sticky), 64'd0);
    chk("arst_cmd_ready", 64'(bus.cmd_ready), 64'd1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    #2;
    chk("post_reset_idle", 64'(bus.cmd_ready), 64'd1);
    chk("strobes_all_seen", 64'(stb_q.size()), 64'd0);
    chk("responses_all_seen", 64'(rsp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
